// File: rtl/music_pkg.sv
// Shared defaults and FSM encoding for the note scheduling blocks.
package music_pkg;

  localparam int unsigned NOTE_W  = 6;
  localparam int unsigned DUR_W   = 6;
  localparam int unsigned BEAT_HZ = 48;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StWait = 1'b1
  } sched_state_e;

endpackage

// File: rtl/voice_select.sv
// Combinational voice picker: lowest-index free voice, otherwise steal the voice with the
// smallest remaining count (lowest index on tie).
module voice_select #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned DUR_W      = music_pkg::DUR_W
) (
  input  logic [NUM_VOICES*DUR_W-1:0] counts_i,
  output logic [NUM_VOICES-1:0]       pick_o,
  output logic                        steal_o
);

  localparam int unsigned IdxW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [IdxW-1:0]  min_idx;
  logic [DUR_W-1:0] min_val;
  logic [DUR_W-1:0] cnt;

  // A strict-less-than scan finds the lowest-index minimum; when that minimum is zero it is
  // exactly the lowest-index free voice, so one scan covers both policies.
  always_comb begin
    min_idx = '0;
    min_val = counts_i[DUR_W-1:0];
    cnt     = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      cnt = counts_i[i*DUR_W +: DUR_W];
      if (cnt < min_val) begin
        min_val = cnt;
        min_idx = IdxW'(i);
      end
    end
    pick_o          = '0;
    pick_o[min_idx] = 1'b1;
    steal_o         = (min_val != '0);
  end

endmodule

// File: rtl/voice_scheduler.sv
// Accepts notes from the song reader, assigns them to voices, counts durations on the beat and
// holds off new notes while an advance note plays.
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = music_pkg::NOTE_W,
  parameter int unsigned DUR_W      = music_pkg::DUR_W
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  play_enable_i,
  input  logic                  beat_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [NOTE_W-1:0]     req_note_i,
  input  logic [DUR_W-1:0]      req_duration_i,
  input  logic                  req_advance_i,
  output logic [NUM_VOICES-1:0] load_new_note_o,
  output logic [NOTE_W-1:0]     load_note_o,
  output logic [NUM_VOICES-1:0] voice_busy_o,
  output logic                  step_done_o,
  output logic                  stolen_o
);

  import music_pkg::*;

  sched_state_e          state_q, state_d;
  logic [DUR_W-1:0]      count_q [NUM_VOICES];
  logic [DUR_W-1:0]      count_d [NUM_VOICES];
  logic [DUR_W-1:0]      adv_count_q, adv_count_d;
  logic [NUM_VOICES-1:0] load_q, load_d;
  logic [NOTE_W-1:0]     load_note_q, load_note_d;
  logic                  step_done_q, step_done_d;
  logic                  stolen_q, stolen_d;

  logic [NUM_VOICES*DUR_W-1:0] counts_flat;
  logic [NUM_VOICES-1:0]       pick;
  logic                        steal;
  logic                        accept;
  logic                        do_load;
  logic                        beat_tick;

  // Ready is gated by reset so nothing looks acceptable while the block is held in reset.
  assign req_ready_o = (state_q == StIdle) && play_enable_i && reset_ni;
  assign accept      = req_valid_i && req_ready_o;
  assign do_load     = accept && (req_duration_i != '0);
  assign beat_tick   = play_enable_i && beat_i;

  always_comb begin
    counts_flat  = '0;
    voice_busy_o = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      counts_flat[i*DUR_W +: DUR_W] = count_q[i];
      voice_busy_o[i]               = (count_q[i] != '0);
    end
  end

  voice_select #(
    .NUM_VOICES(NUM_VOICES),
    .DUR_W     (DUR_W)
  ) u_voice_select (
    .counts_i(counts_flat),
    .pick_o  (pick),
    .steal_o (steal)
  );

  always_comb begin
    state_d     = state_q;
    adv_count_d = adv_count_q;
    load_d      = '0;
    load_note_d = load_note_q;
    step_done_d = 1'b0;
    stolen_d    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      count_d[i] = count_q[i];
      if (beat_tick && (count_q[i] != '0)) begin
        count_d[i] = count_q[i] - DUR_W'(1);
      end
      // A fresh load overrides the same-cycle decrement for that voice only.
      if (do_load && pick[i]) begin
        count_d[i] = req_duration_i;
      end
    end

    if (do_load) begin
      load_d      = pick;
      load_note_d = req_note_i;
      stolen_d    = steal;
    end

    case (state_q)
      StIdle: begin
        if (accept && req_advance_i) begin
          if (req_duration_i != '0) begin
            state_d     = StWait;
            adv_count_d = req_duration_i;
          end else begin
            step_done_d = 1'b1;
          end
        end
      end
      StWait: begin
        if (beat_tick && (adv_count_q != '0)) begin
          adv_count_d = adv_count_q - DUR_W'(1);
          if (adv_count_q == DUR_W'(1)) begin
            state_d     = StIdle;
            step_done_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      adv_count_q <= '0;
      load_q      <= '0;
      load_note_q <= '0;
      step_done_q <= 1'b0;
      stolen_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      adv_count_q <= adv_count_d;
      load_q      <= load_d;
      load_note_q <= load_note_d;
      step_done_q <= step_done_d;
      stolen_q    <= stolen_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  assign load_new_note_o = load_q;
  assign load_note_o     = load_note_q;
  assign step_done_o     = step_done_q;
  assign stolen_o        = stolen_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: reset, chords, stealing, beat/load overlap, rests, pause.
module tb_voice_scheduler;

  localparam int unsigned NV = 4;
  localparam int unsigned NW = 6;
  localparam int unsigned DW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          play_enable = 1'b1;
  logic          beat = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [NW-1:0] req_note = '0;
  logic [DW-1:0] req_duration = '0;
  logic          req_advance = 1'b0;
  logic [NV-1:0] load_new_note;
  logic [NW-1:0] load_note;
  logic [NV-1:0] voice_busy;
  logic          step_done;
  logic          stolen;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_scheduler #(
    .NUM_VOICES(NV),
    .NOTE_W    (NW),
    .DUR_W     (DW)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .play_enable_i  (play_enable),
    .beat_i         (beat),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_note_i     (req_note),
    .req_duration_i (req_duration),
    .req_advance_i  (req_advance),
    .load_new_note_o(load_new_note),
    .load_note_o    (load_note),
    .voice_busy_o   (voice_busy),
    .step_done_o    (step_done),
    .stolen_o       (stolen)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then return 1 time unit after the edge that consumed them.
  task automatic cyc(input logic v, input logic [NW-1:0] note, input logic [DW-1:0] dur,
                     input logic adv, input logic bt);
    req_valid    = v;
    req_note     = note;
    req_duration = dur;
    req_advance  = adv;
    beat         = bt;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    beat      = 1'b0;
  endtask

  initial begin
    // Reset with a pending request.
    req_valid = 1'b1;
    #2 reset_n = 1'b0;
    #21;
    check("rst_ready", req_ready, 0);
    check("rst_load", load_new_note, 0);
    check("rst_note", load_note, 0);
    check("rst_busy", voice_busy, 0);
    check("rst_step", step_done, 0);
    check("rst_stolen", stolen, 0);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rel_ready", req_ready, 1);

    // Chord followed by an advance note.
    cyc(1, 20, 8, 0, 0);
    check("chord_v0", load_new_note, 4'b0001);
    check("chord_n0", load_note, 20);
    cyc(1, 24, 8, 0, 0);
    check("chord_v1", load_new_note, 4'b0010);
    check("chord_n1", load_note, 24);
    cyc(1, 27, 8, 0, 0);
    check("chord_v2", load_new_note, 4'b0100);
    check("chord_n2", load_note, 27);
    cyc(1, 20, 8, 1, 0);
    check("chord_v3", load_new_note, 4'b1000);
    check("chord_n3", load_note, 20);
    check("chord_wait_ready", req_ready, 0);
    check("chord_adv", dut.adv_count_q, 8);
    cyc(1, 5, 3, 0, 0);
    check("wait_reject", load_new_note, 0);
    for (int i = 0; i < 8; i++) begin
      check("wait_ready_lo", req_ready, 0);
      cyc(0, 0, 0, 0, 1);
      if (i < 7) check("wait_no_step", step_done, 0);
    end
    check("wait_step", step_done, 1);
    check("wait_ready_hi", req_ready, 1);
    check("wait_busy", voice_busy, 0);
    cyc(0, 0, 0, 0, 0);
    check("wait_step_once", step_done, 0);

    // Steal the voice with the minimum count.
    cyc(1, 1, 10, 0, 0);
    cyc(1, 2, 5, 0, 0);
    cyc(1, 3, 7, 0, 0);
    cyc(1, 4, 9, 0, 0);
    check("steal_full", voice_busy, 4'b1111);
    check("steal_nostolen", stolen, 0);
    cyc(0, 0, 0, 0, 1);
    check("steal_c0", dut.count_q[0], 9);
    check("steal_c1", dut.count_q[1], 4);
    check("steal_c2", dut.count_q[2], 6);
    check("steal_c3", dut.count_q[3], 8);
    cyc(1, 33, 3, 0, 0);
    check("steal_v1", load_new_note, 4'b0010);
    check("steal_flag", stolen, 1);
    check("steal_note", load_note, 33);
    check("steal_c1_new", dut.count_q[1], 3);
    cyc(0, 0, 0, 0, 0);
    check("steal_flag_clr", stolen, 0);
    check("steal_load_clr", load_new_note, 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 1);
    check("steal_drain", voice_busy, 0);

    // Load on the same edge as a beat.
    cyc(1, 30, 1, 0, 0);
    cyc(1, 31, 3, 0, 0);
    check("ovl_pre_v1", load_new_note, 4'b0010);
    cyc(0, 0, 0, 0, 1);
    check("ovl_c0_free", dut.count_q[0], 0);
    check("ovl_c1_two", dut.count_q[1], 2);
    cyc(1, 40, 4, 0, 1);
    check("ovl_v0", load_new_note, 4'b0001);
    check("ovl_c0", dut.count_q[0], 4);
    check("ovl_c1", dut.count_q[1], 1);
    check("ovl_stolen", stolen, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    check("ovl_drain", voice_busy, 0);

    // Rest with advance.
    cyc(1, 9, 0, 1, 0);
    check("rest_load", load_new_note, 0);
    check("rest_step", step_done, 1);
    check("rest_ready", req_ready, 1);
    check("rest_busy", voice_busy, 0);
    cyc(0, 0, 0, 0, 0);
    check("rest_step_clr", step_done, 0);

    // Pause mid-wait; the registered strobe still ends after one cycle.
    cyc(1, 12, 5, 1, 0);
    check("pause_load", load_new_note, 4'b0001);
    check("pause_adv0", dut.adv_count_q, 5);
    play_enable = 1'b0;
    cyc(0, 0, 0, 0, 1);
    check("pause_strobe_end", load_new_note, 0);
    for (int i = 0; i < 10; i++) cyc(1, 7, 2, 0, 1);
    check("pause_adv", dut.adv_count_q, 5);
    check("pause_c0", dut.count_q[0], 5);
    check("pause_ready", req_ready, 0);
    check("pause_noload", load_new_note, 0);
    play_enable = 1'b1;
    cyc(0, 0, 0, 0, 1);
    check("resume_adv", dut.adv_count_q, 4);
    check("resume_c0", dut.count_q[0], 4);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    check("resume_nostep", step_done, 0);
    cyc(0, 0, 0, 0, 1);
    check("resume_step", step_done, 1);
    check("resume_ready", req_ready, 1);

    // No handshake in IDLE while disabled.
    play_enable = 1'b0;
    #1;
    check("dis_ready", req_ready, 0);
    cyc(1, 7, 3, 0, 0);
    check("dis_noload", load_new_note, 0);
    check("dis_busy", voice_busy, 0);
    play_enable = 1'b1;

    // Asynchronous reset mid-operation.
    cyc(1, 50, 6, 1, 0);
    check("mid_busy_pre", voice_busy, 4'b0001);
    #2 reset_n = 1'b0;
    #1;
    check("mid_busy", voice_busy, 0);
    check("mid_adv", dut.adv_count_q, 0);
    check("mid_load", load_new_note, 0);
    check("mid_ready", req_ready, 0);
    #3 reset_n = 1'b1;
    #1;
    check("mid_rel_ready", req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
